// File: rtl/fifo_uart_tx_if.sv
// Byte-write / status bundle between the upstream formatter stage and the
// FIFO-fed UART transmitter. The writer drives the write strobe and byte and
// observes the FIFO status and the serial line.
interface fifo_uart_tx_if #(
  parameter int DEPTH = 32
);
  logic                     wr_en;
  logic [7:0]               data_i;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     tx;
  logic                     tx_busy;

  modport master (
    output wr_en, data_i,
    input  full, empty, count, overflow, tx, tx_busy
  );

  modport slave (
    input  wr_en, data_i,
    output full, empty, count, overflow, tx, tx_busy
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Byte FIFO feeding an 8N1 UART transmitter. Writes are accepted against the
// registered full flag; the transmitter pops the head byte from IDLE, or
// straight out of the final STOP cycle so consecutive frames have no gap.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 32
) (
  input logic           clk,
  input logic           rstn,
  fifo_uart_tx_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(CLKS_PER_BIT);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Storage carries no reset; only pointers and flags define validity.
  logic [7:0]       mem [DEPTH];
  logic [7:0]       head;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             overflow_q, overflow_d;

  logic             push;
  logic             pop;
  logic             bit_end;

  state_t           state_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             tx_busy_q;

  assign head         = mem[rd_ptr_q];
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.tx       = tx_q;
  assign bus.tx_busy  = tx_busy_q;

  // Push/pop decode; pop only sees the registered empty flag, so a byte written
  // into an empty FIFO is never popped at the edge that stores it.
  always_comb begin
    push    = bus.wr_en & ~full_q;
    bit_end = (bit_cnt_q == BIT_LAST);
    if (state_q == IDLE) begin
      pop = ~empty_q;
    end else if (state_q == STOP) begin
      pop = bit_end & ~empty_q;
    end else begin
      pop = 1'b0;
    end
  end

  // FIFO pointer, occupancy and sticky-overflow next state.
  always_comb begin
    overflow_d = overflow_q | (bus.wr_en & full_q);
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == CNT_ZERO);
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q   <= PTR_W'(0);
      rd_ptr_q   <= PTR_W'(0);
      count_q    <= CNT_ZERO;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte storage write port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.data_i;
    end
  end

  // Transmitter FSM with registered line and busy outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      bit_cnt_q <= BIT_ZERO;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt_q <= BIT_ZERO;
          if (pop) begin
            shift_q   <= head;
            tx_q      <= 1'b0;
            state_q   <= START;
            tx_busy_q <= 1'b1;
          end else begin
            tx_q      <= 1'b1;
            tx_busy_q <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt_q <= BIT_ZERO;
            bit_idx_q <= 3'd0;
            tx_q      <= shift_q[0];
            state_q   <= DATA;
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_ONE;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt_q <= BIT_ZERO;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[bit_idx_q + 3'd1];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_ONE;
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt_q <= BIT_ZERO;
            if (pop) begin
              // Chain straight into the next start bit, no idle cycle.
              shift_q <= head;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              tx_q      <= 1'b1;
              state_q   <= IDLE;
              tx_busy_q <= 1'b0;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_ONE;
          end
        end
        default: begin
          state_q   <= IDLE;
          bit_cnt_q <= BIT_ZERO;
          tx_q      <= 1'b1;
          tx_busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: directed writes push expected bytes into per-instance
// queues; independent line monitors decode every frame and score it.
module tb_fifo_uart_tx;
  localparam int C = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fifo_uart_tx_if #(.DEPTH(4))  ua ();
  fifo_uart_tx_if #(.DEPTH(32)) ub ();

  fifo_uart_tx #(.CLKS_PER_BIT(C), .DEPTH(4))  dut_a (.clk(clk), .rstn(rstn), .bus(ua.slave));
  fifo_uart_tx #(.CLKS_PER_BIT(C), .DEPTH(32)) dut_b (.clk(clk), .rstn(rstn), .bus(ub.slave));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];
  int starts_a [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Decode 40 line samples: {frame_ok, byte}.
  function automatic logic [8:0] decode(input logic [39:0] s);
    logic ok;
    logic [7:0] b;
    ok = 1'b1;
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < C; j++)
        if (s[k*C+j] !== s[k*C]) ok = 1'b0;
    if (s[0] !== 1'b0) ok = 1'b0;
    if (s[9*C] !== 1'b1) ok = 1'b0;
    for (int i = 0; i < 8; i++) b[i] = s[(i+1)*C];
    return {ok, b};
  endfunction

  // Cycle stamp and reset observation at the active edge.
  bit rst_a = 1'b0, rst_b = 1'b0;
  always @(posedge clk) begin
    cyc++;
    if (!rstn) begin
      rst_a = 1'b1;
      rst_b = 1'b1;
    end
  end

  // Monitor for instance A.
  logic [39:0] sa;
  int na = 0;
  bit ina = 1'b0;
  always @(negedge clk) begin
    logic [8:0] d;
    logic [7:0] e;
    if (rst_a) begin
      ina = 1'b0;
      rst_a = 1'b0;
    end else if (!ina) begin
      if (ua.tx === 1'b0) begin
        ina = 1'b1; sa[0] = 1'b0; na = 1; starts_a.push_back(cyc);
      end
    end else begin
      sa[na] = ua.tx; na++;
      if (na == 10*C) begin
        ina = 1'b0;
        d = decode(sa);
        tests++;
        if (exp_a.size() == 0) begin
          fails++;
          $display("FAIL frame_a: unexpected frame %0h", d[7:0]);
        end else begin
          e = exp_a.pop_front();
          if (!d[8] || d[7:0] !== e) begin
            fails++;
            $display("FAIL frame_a: got %0h (shape ok=%0b), expected %0h", d[7:0], d[8], e);
          end
        end
      end
    end
  end

  // Monitor for instance B.
  logic [39:0] sb;
  int nb = 0;
  bit inb = 1'b0;
  always @(negedge clk) begin
    logic [8:0] d;
    logic [7:0] e;
    if (rst_b) begin
      inb = 1'b0;
      rst_b = 1'b0;
    end else if (!inb) begin
      if (ub.tx === 1'b0) begin
        inb = 1'b1; sb[0] = 1'b0; nb = 1;
      end
    end else begin
      sb[nb] = ub.tx; nb++;
      if (nb == 10*C) begin
        inb = 1'b0;
        d = decode(sb);
        tests++;
        if (exp_b.size() == 0) begin
          fails++;
          $display("FAIL frame_b: unexpected frame %0h", d[7:0]);
        end else begin
          e = exp_b.pop_front();
          if (!d[8] || d[7:0] !== e) begin
            fails++;
            $display("FAIL frame_b: got %0h (shape ok=%0b), expected %0h", d[7:0], d[8], e);
          end
        end
      end
    end
  end

  task automatic wait_done(input int which, input int limit, input string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (n < limit && !done) begin
      @(negedge clk);
      n++;
      if (which == 0)
        done = (exp_a.size() == 0) && (ua.tx_busy === 1'b0) && (ua.empty === 1'b1);
      else
        done = (exp_b.size() == 0) && (ub.tx_busy === 1'b0) && (ub.empty === 1'b1);
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s: not drained after %0d cycles, expected drained", name, limit);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    int ns;
    logic [7:0] v;
    ua.wr_en = 1'b0; ua.data_i = 8'h00;
    ub.wr_en = 1'b0; ub.data_i = 8'h00;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", ua.tx, 1);
    check("rst_busy", ua.tx_busy, 0);
    check("rst_empty", ua.empty, 1);
    check("rst_full", ua.full, 0);
    check("rst_count", ua.count, 0);
    check("rst_overflow", ua.overflow, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Single byte 0x61 from idle.
    ua.wr_en = 1'b1; ua.data_i = 8'h61; exp_a.push_back(8'h61);
    @(negedge clk);
    ua.wr_en = 1'b0;
    check("single_count_k", ua.count, 1);
    check("single_empty_k", ua.empty, 0);
    check("single_tx_k", ua.tx, 1);
    @(negedge clk);
    check("single_tx_k1", ua.tx, 0);
    check("single_busy_k1", ua.tx_busy, 1);
    check("single_count_k1", ua.count, 0);
    repeat (39) @(negedge clk);
    check("single_stop_busy", ua.tx_busy, 1);
    check("single_stop_tx", ua.tx, 1);
    @(negedge clk);
    check("single_idle_busy", ua.tx_busy, 0);
    check("single_idle_tx", ua.tx, 1);
    wait_done(0, 20, "single_drain");

    // Back-to-back 0x41, 0x42.
    ns = starts_a.size();
    ua.wr_en = 1'b1; ua.data_i = 8'h41; exp_a.push_back(8'h41);
    @(negedge clk);
    ua.data_i = 8'h42; exp_a.push_back(8'h42);
    @(negedge clk);
    ua.wr_en = 1'b0;
    wait_done(0, 200, "b2b_drain");
    check("b2b_frames", starts_a.size() - ns, 2);
    if (starts_a.size() - ns == 2)
      check("b2b_gap", starts_a[ns+1] - starts_a[ns], 10*C);

    // Overflow: six consecutive writes into DEPTH=4.
    ns = starts_a.size();
    for (int i = 0; i < 6; i++) begin
      v = 8'hB1 + 8'(i);
      ua.wr_en = 1'b1; ua.data_i = v;
      if (i < 5) exp_a.push_back(v);
      if (i == 5) begin
        check("ovf_full5", ua.full, 1);
        check("ovf_count5", ua.count, 4);
        check("ovf_flag5", ua.overflow, 0);
      end
      @(negedge clk);
    end
    ua.wr_en = 1'b0;
    check("ovf_flag6", ua.overflow, 1);
    check("ovf_count6", ua.count, 4);
    check("ovf_full6", ua.full, 1);
    wait_done(0, 400, "ovf_drain");
    check("ovf_frames", starts_a.size() - ns, 5);
    if (starts_a.size() - ns == 5)
      check("ovf_span", starts_a[ns+4] - starts_a[ns], 4*10*C);
    check("ovf_sticky", ua.overflow, 1);

    // Simultaneous push/pop at count=2 on the final STOP edge.
    ua.wr_en = 1'b1; ua.data_i = 8'h31; exp_a.push_back(8'h31);
    @(negedge clk);
    ua.data_i = 8'h32; exp_a.push_back(8'h32);
    @(negedge clk);
    ua.data_i = 8'h33; exp_a.push_back(8'h33);
    @(negedge clk);
    ua.wr_en = 1'b0;
    repeat (38) @(negedge clk);
    check("pp_count_before", ua.count, 2);
    check("pp_tx_stop", ua.tx, 1);
    ua.wr_en = 1'b1; ua.data_i = 8'h34; exp_a.push_back(8'h34);
    @(negedge clk);
    ua.wr_en = 1'b0;
    check("pp_count_after", ua.count, 2);
    check("pp_tx_start", ua.tx, 0);
    wait_done(0, 400, "pp_drain");

    // 21-byte counter burst into DEPTH=32.
    s = "a123456b789ABCc0DEF12";
    for (int i = 0; i < 21; i++) begin
      ub.wr_en = 1'b1; ub.data_i = s[i]; exp_b.push_back(s[i]);
      @(negedge clk);
    end
    ub.wr_en = 1'b0;
    wait_done(1, 21*10*C + 100, "burst_drain");
    check("burst_overflow", ub.overflow, 0);
    check("burst_count", ub.count, 0);

    // Reset during DATA bit 3 with two bytes queued.
    ua.wr_en = 1'b1; ua.data_i = 8'h51;
    @(negedge clk);
    ua.data_i = 8'h52;
    @(negedge clk);
    ua.data_i = 8'h53;
    @(negedge clk);
    ua.wr_en = 1'b0;
    repeat (16) @(negedge clk);
    check("mid_bit3", ua.tx, 0);
    check("mid_count", ua.count, 2);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("mid_rst_tx", ua.tx, 1);
    check("mid_rst_count", ua.count, 0);
    check("mid_rst_empty", ua.empty, 1);
    check("mid_rst_overflow", ua.overflow, 0);
    check("mid_rst_busy", ua.tx_busy, 0);
    ns = starts_a.size();
    repeat (100) @(negedge clk);
    check("mid_no_frames", starts_a.size() - ns, 0);
    check("mid_idle_tx", ua.tx, 1);
    check("mid_idle_busy", ua.tx_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2.
REQ-002 The block SHALL have parameter DEPTH, default 32, FIFO depth in bytes; power of two, >= 2.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 wr_en  input  1  byte write strobe from the upstream counter/formatter stage; one byte per high cycle.
REQ-006 data_i  input  8  ASCII byte written when wr_en is high.
REQ-007 full  output  1  FIFO holds DEPTH bytes.
REQ-008 empty  output  1  FIFO holds 0 bytes.
REQ-009 count  output  log2(DEPTH)+1  bytes currently held.
REQ-010 overflow  output  1  sticky flag: a write was dropped.
REQ-011 tx  output  1  UART serial line, 8N1, idle high, registered.
REQ-012 tx_busy  output  1  high whenever the transmitter is not in IDLE.

Function
REQ-013 A write SHALL be accepted at the edge where wr_en=1 and the registered full=0; the byte is stored and count increments.
REQ-014 A write with full=1 SHALL be dropped, leave FIFO contents and count unchanged, and set overflow to 1; this holds even if a pop occurs at the same edge.
REQ-015 overflow SHALL remain 1 until reset.
REQ-016 A pop and an accepted write at the same edge SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-017 A pop SHALL never occur while empty=1; a write into an empty FIFO SHALL NOT be popped at the same edge.
REQ-018 The transmitter FSM SHALL have states IDLE, START, DATA, STOP.
REQ-019 IDLE: tx=1; at an edge with empty=0, the FSM pops the head byte into a shift register, drives tx<=0, and enters START.
REQ-020 START SHALL last CLKS_PER_BIT cycles, then enter DATA driving bit 0.
REQ-021 DATA SHALL send bits 0..7, LSB first, each held CLKS_PER_BIT cycles, then enter STOP driving tx=1.
REQ-022 STOP SHALL last CLKS_PER_BIT cycles; at its final edge, if empty=0, the FSM SHALL pop the next byte and enter START directly (no idle cycle); otherwise it enters IDLE.
REQ-023 One frame SHALL occupy exactly 10*CLKS_PER_BIT cycles of tx.
REQ-024 With FSM in IDLE and FIFO empty, a write sampled at edge k SHALL cause tx=0 after edge k+1.
REQ-025 The bit-period counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and reset to 0 on every bit boundary.
REQ-026 tx_busy SHALL equal (state != IDLE), registered with state.

Reset
REQ-027 While rstn=0 at a clock edge: FIFO pointers and count=0, empty=1, full=0, overflow=0, FSM=IDLE, tx=1, tx_busy=0, bit counter=0, shift register=0.
REQ-028 A reset asserted mid-frame SHALL abort the frame, with tx=1 after the reset edge; discarded bytes are not retransmitted.
REQ-029 Stored data contents SHALL NOT require reset.

Verification (CLKS_PER_BIT=4, DEPTH=4 unless stated)
REQ-030 Single byte: write 0x61 while idle -> after the next edge tx emits 0,1,0,0,0,0,1,1,0,1, each held 4 cycles (40 cycles), then IDLE with tx_busy=0.
REQ-031 Overflow: wr_en high for 6 consecutive cycles with bytes B1..B6 while idle -> B1 popped at the 2nd edge; B2..B5 stored (full=1 after the 5th edge); B6 dropped; overflow=1; B1..B5 transmitted in order, back-to-back, 200 cycles total.
REQ-032 Back-to-back: write 0x41, 0x42 on consecutive cycles -> the stop bit of 0x41 is followed immediately by the start bit of 0x42, with no extra high cycle.
REQ-033 Counter burst (DEPTH=32): 21-byte burst "a",hex×6,"b",hex×6,"c",hex×6 -> all 21 bytes appear on tx in order, overflow=0, count returns to 0.
REQ-034 Reset mid-frame: assert rstn=0 for 1 cycle during DATA bit 3 with 2 bytes queued -> after the reset edge tx=1, count=0, empty=1, overflow=0, and no further frames are sent.
REQ-035 Simultaneous push/pop at count=2 (edge where STOP ends and wr_en=1) -> count stays 2, and the byte order is preserved.
